// File: rtl/lsb_mem_port_if.sv
// LSB-to-memory request interface: one load/store request per handshake,
// completed by a one-cycle mem_ready pulse carrying the load result.
interface lsb_mem_port_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_valid;
  logic                  mem_wr;
  logic [2:0]            mem_len;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_value;
  logic                  mem_ready;
  logic [31:0]           mem_result;

  // Requester side (the LoadStoreBuffer)
  modport master (
    output mem_valid, mem_wr, mem_len, mem_addr, mem_value,
    input  mem_ready, mem_result
  );

  // Responder side (this memory port)
  modport slave (
    input  mem_valid, mem_wr, mem_len, mem_addr, mem_value,
    output mem_ready, mem_result
  );
endinterface

// File: rtl/lsb_mem_port.sv
// Responder end of the LSB memory request interface. Each accepted load or
// store is run one byte per cycle on the 8-bit RAM/IO bus; completion is a
// one-cycle mem_ready pulse with the sign/zero-extended load data.
module lsb_mem_port #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_TAG     = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_clear,
  lsb_mem_port_if.slave         bus,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [2:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           value_q, value_d;
  logic [31:0]           data_q, data_d;
  logic                  supp_q, supp_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [31:0]           mem_result_q, mem_result_d;
  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;

  logic [2:0] nbytes;
  logic [1:0] byte_idx;
  logic       io_region;
  logic       stall;

  // Byte count of the latched access and the IO-stall condition for stores
  always_comb begin
    unique case (len_q[1:0])
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    byte_idx  = cnt_q[1:0] - 2'd1;
    io_region = (addr_q[17:16] == IO_TAG);
    stall     = (state_q == S_WR) && io_region && io_buffer_full;
  end

  // Sign- or zero-extend the assembled load data according to the access size
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] len);
    logic [31:0] r;
    unique case (len[1:0])
      2'd0:    r = len[2] ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'd1:    r = len[2] ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Next-state and registered-output computation; rdy_in=0 holds everything
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    len_d        = len_q;
    addr_d       = addr_q;
    value_d      = value_q;
    data_d       = data_q;
    supp_d       = supp_q;
    mem_ready_d  = mem_ready_q;
    mem_result_d = mem_result_q;
    ram_a_d      = ram_a_q;
    ram_dout_d   = ram_dout_q;
    ram_wr_d     = ram_wr_q;

    if (rdy_in) begin
      mem_ready_d  = 1'b0;
      mem_result_d = 32'b0;
      ram_a_d      = '0;
      ram_dout_d   = 8'b0;
      ram_wr_d     = 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.mem_valid && !rob_clear) begin
            wr_d    = bus.mem_wr;
            len_d   = bus.mem_len;
            addr_d  = bus.mem_addr;
            value_d = bus.mem_value;
            cnt_d   = 3'd0;
            data_d  = 32'b0;
            supp_d  = 1'b0;
            ram_a_d = bus.mem_addr;
            if (bus.mem_wr) begin
              state_d    = S_WR;
              ram_dout_d = bus.mem_value[7:0];
              ram_wr_d   = 1'b1;
            end else begin
              state_d = S_RD;
            end
          end
        end

        S_RD: begin
          if (rob_clear) begin
            // Flushed load: drop whatever was captured, no completion
            state_d = S_IDLE;
            cnt_d   = 3'd0;
          end else begin
            // ram_din carries the byte addressed in the previous cycle
            if (cnt_q != 3'd0) begin
              data_d[{byte_idx, 3'b000} +: 8] = ram_din;
            end
            if (cnt_q == nbytes) begin
              state_d      = S_IDLE;
              mem_ready_d  = 1'b1;
              mem_result_d = extend(data_d, len_q);
            end else begin
              cnt_d = cnt_q + 3'd1;
              if (cnt_d < nbytes) begin
                ram_a_d = addr_q + ADDR_WIDTH'(cnt_d);
              end
            end
          end
        end

        S_WR: begin
          // A flushed store still completes on the bus but reports nothing
          supp_d = supp_q | rob_clear;
          if (stall) begin
            ram_a_d    = ram_a_q;
            ram_dout_d = ram_dout_q;
            ram_wr_d   = 1'b1;
          end else if (cnt_q == nbytes - 3'd1) begin
            state_d     = S_IDLE;
            mem_ready_d = !(supp_q | rob_clear);
          end else begin
            cnt_d      = cnt_q + 3'd1;
            ram_a_d    = addr_q + ADDR_WIDTH'(cnt_d);
            ram_dout_d = value_q[{cnt_d[1:0], 3'b000} +: 8];
            ram_wr_d   = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      wr_q         <= 1'b0;
      len_q        <= 3'd0;
      addr_q       <= '0;
      value_q      <= 32'b0;
      data_q       <= 32'b0;
      supp_q       <= 1'b0;
      mem_ready_q  <= 1'b0;
      mem_result_q <= 32'b0;
      ram_a_q      <= '0;
      ram_dout_q   <= 8'b0;
      ram_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      value_q      <= value_d;
      data_q       <= data_d;
      supp_q       <= supp_d;
      mem_ready_q  <= mem_ready_d;
      mem_result_q <= mem_result_d;
      ram_a_q      <= ram_a_d;
      ram_dout_q   <= ram_dout_d;
      ram_wr_q     <= ram_wr_d;
    end
  end

  // The write strobe is masked in the very cycle the IO sink reports full,
  // so a stalled byte never reaches the bus and is retried next cycle.
  assign ram_wr         = ram_wr_q & ~stall;
  assign ram_a          = ram_a_q;
  assign ram_dout       = ram_dout_q;
  assign bus.mem_ready  = mem_ready_q;
  assign bus.mem_result = mem_result_q;

  // wr_q is kept for observability of the latched request kind
  logic unused_ok;
  assign unused_ok = wr_q;

endmodule

// File: tb/tb_lsb_mem_port.sv
// Directed bench for lsb_mem_port: table of single requests plus hand
// sequences for back-to-back, IO stall, flush, freeze and async reset.
module tb_lsb_mem_port;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full;

  lsb_mem_port_if #(.ADDR_WIDTH(32)) bus ();

  lsb_mem_port #(.ADDR_WIDTH(32), .IO_TAG(2'b11)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .rob_clear      (rob_clear),
    .bus            (bus),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_a          (ram_a),
    .ram_wr         (ram_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // RAM model: registered read, frozen together with the rest of the system
  logic [7:0]  ram [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_a  = 16'h0;
  logic [7:0]  ld_d  = 8'h0;

  always @(posedge clk_in) begin
    if (ld_en) begin
      ram[ld_a] <= ld_d;
    end else if (rdy_in) begin
      if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
      ram_din <= ram[ram_a[15:0]];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic [2:0] len,
                         input logic [31:0] addr, input logic [31:0] value);
    bus.mem_valid = 1'b1;
    bus.mem_wr    = wr;
    bus.mem_len   = len;
    bus.mem_addr  = addr;
    bus.mem_value = value;
  endtask

  // Follow one request from cycle A to its completion cycle A+lat
  task automatic track(input string name, input logic wr, input logic [2:0] len,
                       input logic [31:0] addr, input logic [31:0] value,
                       input logic [31:0] exp_res, input int lat, input bit keep);
    int nb;
    logic [31:0] v;
    nb = (len[1:0] == 2'd0) ? 1 : (len[1:0] == 2'd1) ? 2 : 4;
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k <= nb) begin
        chk($sformatf("%s ram_a c%0d", name, k), ram_a, addr + 32'(k - 1));
        chk($sformatf("%s ram_wr c%0d", name, k), {31'b0, ram_wr}, {31'b0, wr});
        if (wr) begin
          v = value >> (8 * (k - 1));
          chk($sformatf("%s ram_dout c%0d", name, k), {24'b0, ram_dout}, {24'b0, v[7:0]});
        end
      end
      chk($sformatf("%s mem_ready c%0d", name, k), {31'b0, bus.mem_ready}, (k == lat) ? 32'd1 : 32'd0);
      if (k == lat) begin
        chk($sformatf("%s mem_result", name), bus.mem_result, exp_res);
        $display("req %s wr=%0b len=%0d addr=%h -> result %h (ready after %0d cycles)",
                 name, wr, len, addr, bus.mem_result, k);
        if (!keep) bus.mem_valid = 1'b0;
      end
    end
  endtask

  task automatic do_req(input string name, input logic wr, input logic [2:0] len,
                        input logic [31:0] addr, input logic [31:0] value,
                        input logic [31:0] exp_res, input int lat);
    set_req(wr, len, addr, value);
    track(name, wr, len, addr, value, exp_res, lat, 1'b0);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] value;
    logic [31:0] exp_res;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  pre_d [6];
    logic [15:0] pre_a [6];

    // Requests with hand-computed results and latencies (N+2 loads, N+1 stores)
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h1234_5678, 6};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0200, 32'h0,         32'hFFFF_FF80, 3};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0200, 32'h0,         32'h0000_0080, 3};
    vecs[3]  = '{1'b0, 3'b101, 32'h0000_0200, 32'h0,         32'h0000_FF80, 4};
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_0200, 32'h0,         32'hFFFF_FF80, 4};
    vecs[5]  = '{1'b0, 3'b000, 32'h0000_0201, 32'h0,         32'hFFFF_FFFF, 3};
    vecs[6]  = '{1'b1, 3'b001, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0,         3};
    vecs[7]  = '{1'b0, 3'b101, 32'h0000_0300, 32'h0,         32'h0000_BEEF, 4};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,         5};
    vecs[9]  = '{1'b0, 3'b011, 32'h0000_0400, 32'h0,         32'hCAFE_F00D, 6};
    vecs[10] = '{1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0,         5};
    vecs[11] = '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,         32'h1122_3344, 6};
    vecs[12] = '{1'b1, 3'b000, 32'h0000_0401, 32'h0000_00AB, 32'h0,         2};
    vecs[13] = '{1'b0, 3'b010, 32'h0000_0400, 32'h0,         32'hCAFE_AB0D, 6};

    pre_a = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0200, 16'h0201};
    pre_d = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h80, 8'hFF};

    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_wr = 1'b0; bus.mem_len = 3'd0;
    bus.mem_addr = 32'h0; bus.mem_value = 32'h0;

    step();
    for (int i = 0; i < 6; i++) begin
      ld_en = 1'b1; ld_a = pre_a[i]; ld_d = pre_d[i];
      step();
    end
    ld_en = 1'b0;

    // Reset state
    chk("rst mem_ready", {31'b0, bus.mem_ready}, 32'd0);
    chk("rst mem_result", bus.mem_result, 32'd0);
    chk("rst ram_a", ram_a, 32'd0);
    chk("rst ram_dout", {24'b0, ram_dout}, 32'd0);
    chk("rst ram_wr", {31'b0, ram_wr}, 32'd0);
    rst_in = 1'b1;
    step();

    // Table of single requests
    for (int i = 0; i < 14; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].len, vecs[i].addr,
             vecs[i].value, vecs[i].exp_res, vecs[i].lat);
    end

    // Back-to-back: second LW presented in the mem_ready cycle of the first
    set_req(1'b0, 3'b010, 32'h100, 32'h0);
    track("b2b_first", 1'b0, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 6, 1'b1);
    set_req(1'b0, 3'b010, 32'h400, 32'h0);
    track("b2b_second", 1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFE_AB0D, 6, 1'b0);

    // IO store stalled by io_buffer_full in A+1..A+3
    set_req(1'b1, 3'b000, 32'h0003_0000, 32'h0000_005A);
    for (int k = 1; k <= 5; k++) begin
      step();
      io_buffer_full = (k <= 3);
      #1;
      if (k <= 3) chk($sformatf("io ram_wr c%0d", k), {31'b0, ram_wr}, 32'd0);
      if (k == 4) begin
        chk("io ram_wr c4", {31'b0, ram_wr}, 32'd1);
        chk("io ram_a c4", ram_a, 32'h0003_0000);
        chk("io ram_dout c4", {24'b0, ram_dout}, 32'h5A);
      end
      chk($sformatf("io mem_ready c%0d", k), {31'b0, bus.mem_ready}, (k == 5) ? 32'd1 : 32'd0);
      if (k == 5) begin
        chk("io mem_result", bus.mem_result, 32'd0);
        chk("io ram byte", {24'b0, ram[16'h0000]}, 32'h5A);
        $display("req io_store addr=00030000 -> ready after %0d cycles", k);
        bus.mem_valid = 1'b0;
      end
    end

    // Load flushed at A+2: never completes, bus returns to idle
    set_req(1'b0, 3'b010, 32'h100, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) bus.mem_valid = 1'b0;
      rob_clear = (k == 2);
      if (k == 3) chk("flush_rd ram_a idle", ram_a, 32'd0);
      chk($sformatf("flush_rd mem_ready c%0d", k), {31'b0, bus.mem_ready}, 32'd0);
    end
    $display("req flushed_load addr=00000100 -> no completion");
    do_req("after_flush", 1'b0, 3'b000, 32'h200, 32'h0, 32'hFFFF_FF80, 3);

    // Store flushed at A+2: all bytes still written, completion suppressed
    set_req(1'b1, 3'b010, 32'h500, 32'hA1B2_C3D4);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) bus.mem_valid = 1'b0;
      rob_clear = (k == 2);
      if (k <= 4) chk($sformatf("flush_wr ram_wr c%0d", k), {31'b0, ram_wr}, 32'd1);
      chk($sformatf("flush_wr mem_ready c%0d", k), {31'b0, bus.mem_ready}, 32'd0);
    end
    chk("flush_wr byte0", {24'b0, ram[16'h0500]}, 32'hD4);
    chk("flush_wr byte3", {24'b0, ram[16'h0503]}, 32'hA1);
    $display("req flushed_store addr=00000500 -> written, no completion");

    // Two frozen cycles in the middle of a LW
    set_req(1'b0, 3'b010, 32'h100, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 3) rdy_in = 1'b0;
      if (k == 5) rdy_in = 1'b1;
      chk($sformatf("freeze mem_ready c%0d", k), {31'b0, bus.mem_ready}, (k == 8) ? 32'd1 : 32'd0);
      if (k == 8) begin
        chk("freeze mem_result", bus.mem_result, 32'h1234_5678);
        $display("req frozen_load addr=00000100 -> result %h (ready after %0d cycles)", bus.mem_result, k);
        bus.mem_valid = 1'b0;
      end
    end

    // Asynchronous reset in the middle of a SW
    set_req(1'b1, 3'b010, 32'h600, 32'h0102_0304);
    step();
    step();
    chk("arst pre ram_wr", {31'b0, ram_wr}, 32'd1);
    bus.mem_valid = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst ram_wr", {31'b0, ram_wr}, 32'd0);
    chk("arst ram_a", ram_a, 32'd0);
    chk("arst ram_dout", {24'b0, ram_dout}, 32'd0);
    chk("arst mem_ready", {31'b0, bus.mem_ready}, 32'd0);
    chk("arst mem_result", bus.mem_result, 32'd0);
    step();
    chk("arst held ram_wr", {31'b0, ram_wr}, 32'd0);
    rst_in = 1'b1;
    step();
    $display("req reset_mid_store addr=00000600 -> aborted by reset");
    do_req("after_reset", 1'b0, 3'b000, 32'h200, 32'h0, 32'hFFFF_FF80, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
